// File: rtl/lab4_branch_pkg.sv
// Shared types and constants for the branch direction predictor.
package lab4_branch_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int BIMODAL = 0;
  localparam int GSHARE  = 1;

endpackage

// File: rtl/lab4_branch_sat_ctr.sv
// Saturating up/down next-value logic for one pattern-history counter.
module lab4_branch_sat_ctr #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] value,
  input  logic                inc,
  output logic [CTR_BITS-1:0] next
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);

  always_comb begin
    next = value;
    if (inc) begin
      if (value != CTR_MAX) next = value + CTR_ONE;
    end else begin
      if (value != '0) next = value - CTR_ONE;
    end
  end

endmodule

// File: rtl/lab4_branch_gshare_predictor.sv
// Bimodal/gshare branch direction predictor: PHT of saturating counters,
// swept to CTR_INIT after reset, then looked up combinationally and trained on resolve.
//
// state | meaning
// INIT  | sweeping CTR_INIT into every PHT entry, one per cycle
// RUN   | predicting and accepting updates
module lab4_branch_gshare_predictor
  import lab4_branch_pkg::*;
#(
  parameter int PHT_SIZE = 2048,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 11,
  parameter int MODE     = 1,
  parameter int CTR_INIT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         pred_pc,
  output logic                pred_taken,
  output logic                ready,
  input  logic                upd_val,
  output logic                upd_rdy,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  output logic [GHR_BITS-1:0] ghr
);

  localparam int IW = $clog2(PHT_SIZE);

  state_t                state;
  state_t                state_nxt;
  logic [IW-1:0]         init_ptr;
  logic [CTR_BITS-1:0]   pht [PHT_SIZE];
  logic [IW-1:0]         ghr_ext;
  logic [IW-1:0]         pred_idx;
  logic [IW-1:0]         upd_idx;
  logic                  fire;
  logic [CTR_BITS-1:0]   upd_cur;
  logic [CTR_BITS-1:0]   upd_next;
  logic                  wr_en;
  logic [IW-1:0]         wr_idx;
  logic [CTR_BITS-1:0]   wr_data;
  logic [GHR_BITS-1:0]   ghr_shift;
  logic                  unused_pc_bits;

  // Only PC[IW+1:2] select an entry; the rest are deliberately ignored.
  assign unused_pc_bits = ^{pred_pc[31:IW+2], pred_pc[1:0], upd_pc[31:IW+2], upd_pc[1:0]};

  assign ghr_ext  = (MODE == GSHARE) ? IW'(ghr) : '0;
  assign pred_idx = pred_pc[IW+1:2] ^ ghr_ext;
  assign upd_idx  = upd_pc[IW+1:2] ^ ghr_ext;
  assign fire     = upd_val && upd_rdy && !reset;
  assign upd_cur  = pht[upd_idx];

  lab4_branch_sat_ctr #(.CTR_BITS(CTR_BITS)) u_sat_ctr (
    .value (upd_cur),
    .inc   (upd_taken),
    .next  (upd_next)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_ptr == IW'(PHT_SIZE - 1)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    ready      = 1'b0;
    upd_rdy    = 1'b0;
    pred_taken = 1'b0;
    if (state == RUN) begin
      ready      = 1'b1;
      upd_rdy    = 1'b1;
      pred_taken = pht[pred_idx][CTR_BITS-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)              init_ptr <= '0;
    else if (state == INIT) init_ptr <= init_ptr + IW'(1);
  end

  generate
    if (GHR_BITS == 1) begin : g_ghr_one
      assign ghr_shift = upd_taken;
    end else begin : g_ghr_many
      assign ghr_shift = {ghr[GHR_BITS-2:0], upd_taken};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)     ghr <= '0;
    else if (fire) ghr <= ghr_shift;
  end

  // Single write port shared by the init sweep and training; reset blocks both.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = init_ptr;
    wr_data = CTR_BITS'(CTR_INIT);
    if (!reset) begin
      if (state == INIT) begin
        wr_en = 1'b1;
      end else if (fire) begin
        wr_en   = 1'b1;
        wr_idx  = upd_idx;
        wr_data = upd_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) pht[wr_idx] <= wr_data;
  end

endmodule

// File: tb/tb_lab4_branch_gshare_predictor.sv
// Self-checking bench: bimodal and gshare instances share stimulus and are
// compared every cycle against an entry-level predictor model.
module tb_lab4_branch_gshare_predictor;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pred_pc = '0;
  logic [31:0] upd_pc = '0;
  logic        upd_val = 1'b0;
  logic        upd_taken = 1'b0;

  logic       pred_b, ready_b, rdy_b;
  logic       pred_g, ready_g, rdy_g;
  logic [3:0] ghr_b, ghr_g;

  lab4_branch_gshare_predictor #(
    .PHT_SIZE(N), .CTR_BITS(2), .GHR_BITS(4), .MODE(0), .CTR_INIT(1)
  ) u_bim (
    .clk(clk), .reset(reset), .pred_pc(pred_pc), .pred_taken(pred_b),
    .ready(ready_b), .upd_val(upd_val), .upd_rdy(rdy_b), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .ghr(ghr_b)
  );

  lab4_branch_gshare_predictor #(
    .PHT_SIZE(N), .CTR_BITS(2), .GHR_BITS(4), .MODE(1), .CTR_INIT(1)
  ) u_gsh (
    .clk(clk), .reset(reset), .pred_pc(pred_pc), .pred_taken(pred_g),
    .ready(ready_g), .upd_val(upd_val), .upd_rdy(rdy_g), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .ghr(ghr_g)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: counters per instance (0 = bimodal, 1 = gshare), shared history.
  int m_pht [2][N];
  int m_ghr = 0;
  int m_init_left = 0;
  bit m_valid = 1'b0;

  function automatic int m_idx(input int mode, input logic [31:0] pc);
    int base;
    base = int'(pc[5:2]);
    return (mode == 1) ? (base ^ m_ghr) : base;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid     = 1'b1;
      m_init_left = N;
      m_ghr       = 0;
    end else if (m_valid) begin
      if (m_init_left > 0) begin
        m_init_left--;
        if (m_init_left == 0)
          for (int e = 0; e < N; e++) begin
            m_pht[0][e] = 1;
            m_pht[1][e] = 1;
          end
      end else if (upd_val) begin
        for (int md = 0; md < 2; md++) begin
          int i;
          i = m_idx(md, upd_pc);
          if (upd_taken) m_pht[md][i] = (m_pht[md][i] >= 3) ? 3 : m_pht[md][i] + 1;
          else           m_pht[md][i] = (m_pht[md][i] <= 0) ? 0 : m_pht[md][i] - 1;
        end
        m_ghr = ((m_ghr << 1) | int'(upd_taken)) & 15;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      int er;
      er = (m_init_left == 0) ? 1 : 0;
      check("ready_bim", int'(ready_b), er);
      check("ready_gsh", int'(ready_g), er);
      check("upd_rdy_bim", int'(rdy_b), er);
      check("upd_rdy_gsh", int'(rdy_g), er);
      check("ghr_bim", int'(ghr_b), m_ghr);
      check("ghr_gsh", int'(ghr_g), m_ghr);
      check("pred_bim", int'(pred_b), er ? int'(m_pht[0][m_idx(0, pred_pc)] >= 2) : 0);
      check("pred_gsh", int'(pred_g), er ? int'(m_pht[1][m_idx(1, pred_pc)] >= 2) : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Counts not-ready cycles after a reset edge; bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (ready_b && ready_g) break;
      n++;
    end
    upd_val = 1'b0;
    tick();
  endtask

  task automatic upd(input logic [31:0] pc, input logic t);
    upd_val   = 1'b1;
    upd_pc    = pc;
    upd_taken = t;
    tick();
    upd_val = 1'b0;
  endtask

  initial begin
    int n;
    bit seq_t [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int seq_g [5] = '{1, 2, 5, 11, 7};

    tick();
    // Update request held through reset and init must be ignored.
    upd_val = 1'b1; upd_pc = 32'h8; upd_taken = 1'b1;
    do_reset();
    wait_ready(n);
    check("init_cycles", n, 16);
    check("ghr_after_init", int'(ghr_b), 0);

    // Bimodal saturation on pc 0x8.
    pred_pc = 32'h8; #1;
    check("bim_init_pred", int'(pred_b), 0);
    upd(32'h8, 1'b1); check("bim_T1", int'(pred_b), 1);
    upd(32'h8, 1'b1); check("bim_T2", int'(pred_b), 1);
    repeat (3) upd(32'h8, 1'b1);
    upd(32'h8, 1'b0); check("bim_sat_hi_N1", int'(pred_b), 1);
    upd(32'h8, 1'b0); check("bim_sat_hi_N2", int'(pred_b), 0);
    repeat (2) upd(32'h8, 1'b0);
    check("bim_N4", int'(pred_b), 0);
    upd(32'h8, 1'b1); check("bim_sat_lo_T1", int'(pred_b), 0);
    upd(32'h8, 1'b1); check("bim_sat_lo_T2", int'(pred_b), 1);

    // Gshare indexing and history shift.
    do_reset();
    wait_ready(n);
    check("init_cycles_2", n, 16);
    upd(32'h0, seq_t[0]);
    check("ghr_seq0", int'(ghr_g), seq_g[0]);
    pred_pc = 32'h4; #1;
    check("gsh_xor_pred", int'(pred_g), 1);
    check("bim_pc4_pred", int'(pred_b), 0);
    for (int i = 1; i < 5; i++) begin
      upd(32'h0, seq_t[i]);
      check("ghr_seq", int'(ghr_g), seq_g[i]);
    end

    // Same-cycle lookup and update of one bimodal entry: no bypass.
    pred_pc = 32'h8; upd_pc = 32'h8; upd_taken = 1'b1; upd_val = 1'b1; #2;
    check("nobypass_old", int'(pred_b), 0);
    tick();
    upd_val = 1'b0;
    check("nobypass_new", int'(pred_b), 1);

    // Reset mid-INIT, then again mid-RUN with an update pending.
    do_reset();
    repeat (6) tick();
    do_reset();
    wait_ready(n);
    check("init_restart_mid_init", n, 16);
    repeat (3) upd(32'hC, 1'b1);
    upd_val = 1'b1; upd_pc = 32'hC; upd_taken = 1'b1;
    do_reset();
    upd_val = 1'b0;
    wait_ready(n);
    check("init_restart_mid_run", n, 16);
    check("ghr_zero_after_reset", int'(ghr_g), 0);
    for (int p = 0; p < N; p++) begin
      pred_pc = 32'hF000_0003 | (32'(p) << 2); #1;
      check("reinit_pred_bim", int'(pred_b), 0);
      check("reinit_pred_gsh", int'(pred_g), 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
